rr_burst_arbiter: RTL

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

---
 rtl/rr_burst_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one requester owns the output for up to BURST_LEN beats.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_burst_arbiter #(
  parameter int WIDTH         = 8,
  parameter int NUM_REQ       = 4,
  parameter int BURST_LEN     = 16,
  parameter int COUNTER_WIDTH = 8,
  parameter int TIMEOUT       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid,
  output logic                     busy,
  output logic                     timeout
);

  localparam int OW = $clog2(NUM_REQ);
  localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_ACTIVE,
    STATE_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [OW-1:0]            owner_q, owner_d;
  logic [OW-1:0]            last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic                     valid_q, valid_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;

  logic [OW-1:0] pick;
  logic          pick_found;
  logic          owner_req;
  logic          beat;
  logic          last_beat;
  logic          stall_hit;

  // Search upward from the previous owner so the last winner has lowest priority.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found && req[(int'(last_owner_q) + k) % NUM_REQ]) begin
        pick       = OW'((int'(last_owner_q) + k) % NUM_REQ);
        pick_found = 1'b1;
      end
    end
  end

  assign owner_req = req[owner_q];
  assign beat      = (state_q == STATE_ACTIVE) && owner_req && out_ready;
  assign last_beat = beat && (cnt_q == LAST_CNT);

`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d   = stall_q;
    stall_hit = 1'b0;
    if ((state_q != STATE_ACTIVE) || beat) begin
      stall_d = '0;
    end else if (owner_req) begin
      stall_hit = (stall_q == SW'(TIMEOUT - 1));
      stall_d   = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (pick_found) begin
          owner_d = pick;
          gnt_d   = NUM_REQ'(1) << pick;
          cnt_d   = '0;
          state_d = STATE_ACTIVE;
        end
      end
      STATE_ACTIVE: begin
        if (beat) begin
          data_d  = req_data[int'(owner_q)*WIDTH +: WIDTH];
          valid_d = 1'b1;
          // Hold the count on the final beat so a full-range burst never wraps.
          if (last_beat) begin
            state_d = STATE_DONE;
            gnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!owner_req) begin
          state_d = STATE_DONE;
          gnt_d   = '0;
        end else if (stall_hit) begin
          state_d   = STATE_DONE;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      STATE_DONE: begin
        last_owner_d = owner_q;
        gnt_d        = '0;
        state_d      = STATE_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= STATE_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      gnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign gnt      = gnt_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = (state_q != STATE_IDLE);
  assign timeout  = timeout_q;

endmodule
